mul_4bit_seq: RTL and testbench
===============================

MUL_4BIT_SEQ -- requirements
Module: mul_4bit_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 A  input  4  multiplicand, unsigned; captured on the accepting edge.
REQ-006 B  input  4  multiplier, unsigned; captured on the accepting edge.
REQ-007 Product  output  8  registered unsigned result A*B of the last completed operation.
REQ-008 Busy  output  1  high while an operation is in progress (state != IDLE).
REQ-009 Done  output  1  one-cycle pulse marking a newly valid Product.

Function
REQ-010 The block SHALL compute Product = A*B with a shift-and-add algorithm over four iterations, unsigned.
REQ-011 Internal registers SHALL be: M[3:0] multiplicand, Q[3:0] multiplier/low product, ACC[3:0] high partial product, C carry bit, CNT[1:0] iteration counter.
REQ-012 Each partial-product addition SHALL be ACC + (Q[0] ? M : 0), using one instance of the existing cla_4bit adder; Cout feeds C.
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 IDLE: on a rising edge with Start=1: M<=A, Q<=B, ACC<=0, C<=0, CNT<=0, state<=CALC; with Start=0 the state is held.
REQ-015 CALC, each edge: {C,ACC,Q} <= {0, Cout, Sum, Q[3:1]}, i.e. the 9-bit value {Cout,Sum,Q} shifted right by one; CNT<=CNT+1.
REQ-016 CALC SHALL exit to DONE on the edge where CNT==3 (4th iteration); on that edge Product <= {new ACC, new Q}.
REQ-017 DONE: Done=1 for exactly that one cycle; the next edge SHALL go to IDLE unconditionally.
REQ-018 Latency: Start accepted at edge k -> Product updated and Done high from edge k+4 to edge k+5; earliest next accept at edge k+6.
REQ-019 Start while Busy=1 (CALC or DONE) SHALL be ignored and SHALL NOT alter A/B capture or timing.
REQ-020 A and B SHALL be don't-care outside the accepting edge; changes during CALC SHALL NOT affect the result.
REQ-021 Product SHALL hold its value between completions, including across ignored Start pulses.
REQ-022 Busy and Done SHALL be decoded from the state register only (glitch-free, no combinational path from inputs).
REQ-023 The Cout of the adder SHALL never be lost: 15*15 SHALL yield 225, not a truncated value.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force state=IDLE and M, Q, ACC, C, CNT, Product to 0.
REQ-025 During and after reset until the first accepted Start: Product=0x00, Busy=0, Done=0.
REQ-026 Reset asserted mid-CALC or in DONE SHALL abort the operation; no Done pulse SHALL follow, and Product SHALL read 0.
REQ-027 After rst_n rises, the first rising edge with Start=1 SHALL be accepted normally.

Verification
REQ-028 A=15, B=15, Start pulse 1 cycle -> Busy high 5 cycles, Done one cycle 4 edges after accept, Product=0xE1.
REQ-029 Exhaustive: all 256 (A,B) pairs sequentially -> Product == A*B on every Done; exactly one Done per accepted Start.
REQ-030 A=0, B=9 and A=9, B=0 -> Product=0x00; A=1, B=15 -> 0x0F; A=8, B=8 -> 0x40.
REQ-031 A=3, B=5 accepted; Start held high and A/B changed to 15/15 during CALC and DONE -> Product=0x0F, single Done, next accept at edge k+6.
REQ-032 A=12, B=13 accepted; rst_n pulsed low 2 cycles after accept -> Busy=0, Done never asserts, Product=0x00; then A=12, B=13 -> 0x9C.
REQ-033 Back-to-back: Start held high continuously with A=7, B=6 -> Done every 6 cycles, Product=0x2A each time.

Source files
------------

// File: rtl/mul_4bit_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// One partial-product add per clock through a 4-bit carry-lookahead adder,
// four iterations per operation, result registered on the final iteration.
//
// Handshake: Start is sampled only while idle (Busy=0); the accepting edge
// captures A and B. Busy stays high through CALC and DONE, and Done pulses
// for exactly one cycle alongside the newly valid Product. Start pulses seen
// while Busy=1 are dropped without effect.

// 4-bit carry-lookahead adder: all carries computed from generate/propagate terms.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module mul_4bit_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] Product,
    output logic       Busy,
    output logic       Done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] m_q, m_d;
    logic [3:0] q_q, q_d;
    logic [3:0] acc_q, acc_d;
    logic       c_q, c_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;

    logic [3:0] addend;
    logic [3:0] add_sum;
    logic       add_cout;
    logic [8:0] shift_val;

    // Partial-product selection: add the multiplicand only when the current
    // multiplier LSB is set. C is cleared on accept and after every shift, so
    // using it as carry-in leaves the addition as ACC + addend.
    always_comb begin
        addend = q_q[0] ? m_q : 4'd0;
    end

    cla_4bit u_add (
        .a    (acc_q),
        .b    (addend),
        .cin  (c_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {Cout,Sum,Q} shifted right by one; the adder carry lands in ACC[3].
    always_comb begin
        shift_val = {1'b0, add_cout, add_sum, q_q[3:1]};
    end

    // Next-state and datapath update for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = 4'd0;
                    c_d     = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                c_d   = shift_val[8];
                acc_d = shift_val[7:4];
                q_d   = shift_val[3:0];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    product_d = shift_val[7:0];
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= 4'd0;
            q_q       <= 4'd0;
            acc_q     <= 4'd0;
            c_q       <= 1'b0;
            cnt_q     <= 2'd0;
            product_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Status decoded from the state register only.
    always_comb begin
        Busy    = (state_q != S_IDLE);
        Done    = (state_q == S_DONE);
        Product = product_q;
    end
endmodule

// File: tb/tb_mul_4bit_seq.sv
// Bench for mul_4bit_seq: directed table, hold/ignore/back-to-back sequences,
// mid-operation reset, exhaustive sweep and randomized operations.
module tb_mul_4bit_seq;
    logic       clk;
    logic       rst_n;
    logic       Start;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] Product;
    logic       Busy;
    logic       Done;

    int n_vec;
    int n_err;
    logic [7:0] prev_prod;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    mul_4bit_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Product (Product),
        .Busy    (Busy),
        .Done    (Done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain unsigned multiplication.
    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int r;
        r = int'(a) * int'(b);
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One operation, entered and left at a falling edge with the DUT idle.
    // mode: 0 keep A/B, 1 randomize A/B every cycle while busy, 2 force A/B to 15/15.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                          input bit hold_start, input int mode);
        check("idle_busy", 32'(Busy), 32'd0);
        Start = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) Start = 1'b0;
        if (mode == 2) begin
            A = 4'd15;
            B = 4'd15;
        end
        for (int i = 0; i < 4; i++) begin
            check("calc_busy", 32'(Busy), 32'd1);
            check("calc_done", 32'(Done), 32'd0);
            check("calc_prod_hold", 32'(Product), 32'(prev_prod));
            if (mode == 1) begin
                A = 4'($urandom_range(0, 15));
                B = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        check("done_pulse", 32'(Done), 32'd1);
        check("done_busy", 32'(Busy), 32'd1);
        check("done_product", 32'(Product), 32'(exp));
        @(negedge clk);
        check("after_done", 32'(Done), 32'd0);
        check("after_busy", 32'(Busy), 32'd0);
        check("after_product", 32'(Product), 32'(exp));
        prev_prod = exp;
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] e;

        n_vec = 0;
        n_err = 0;
        prev_prod = 8'd0;
        vecs[0] = '{4'd15, 4'd15, 8'hE1};
        vecs[1] = '{4'd0,  4'd9,  8'h00};
        vecs[2] = '{4'd9,  4'd0,  8'h00};
        vecs[3] = '{4'd1,  4'd15, 8'h0F};
        vecs[4] = '{4'd8,  4'd8,  8'h40};
        vecs[5] = '{4'd12, 4'd13, 8'h9C};
        vecs[6] = '{4'd7,  4'd6,  8'h2A};
        vecs[7] = '{4'd3,  4'd5,  8'h0F};

        // Reset state, with Start high to show it has no effect in reset.
        rst_n = 1'b0;
        Start = 1'b1;
        A = 4'd5;
        B = 4'd5;
        #3;
        check("reset_product", 32'(Product), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        Start = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 0);

        // Start held high with A/B changed during the operation; next accept at k+6.
        run_op(4'd3, 4'd5, 8'h0F, 1'b1, 2);
        run_op(4'd15, 4'd15, 8'hE1, 1'b0, 0);

        // Back-to-back with Start held continuously.
        for (int i = 0; i < 3; i++) run_op(4'd7, 4'd6, 8'h2A, 1'b1, 0);
        Start = 1'b0;
        @(negedge clk);

        // Reset asserted mid-operation.
        Start = 1'b1;
        A = 4'd12;
        B = 4'd13;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_product", 32'(Product), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("in_reset_done", 32'(Done), 32'd0);
        end
        rst_n = 1'b1;
        prev_prod = 8'd0;
        repeat (6) begin
            @(negedge clk);
            check("post_abort_done", 32'(Done), 32'd0);
            check("post_abort_busy", 32'(Busy), 32'd0);
            check("post_abort_product", 32'(Product), 32'd0);
        end
        run_op(4'd12, 4'd13, 8'h9C, 1'b0, 0);

        // Exhaustive sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), ref_mul(4'(a), 4'(b)), 1'b0, 0);
            end
        end

        // Randomized operations with A/B scrambled while busy.
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            exp_q.push_back(ref_mul(ra, rb));
            e = exp_q.pop_front();
            run_op(ra, rb, e, ($urandom_range(0, 1) == 1), 1);
        end
        Start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
